bram_axis_reader: RTL and testbench
===================================

Name: bram_axis_reader

Overview:
- Downstream consumer of the single-port block RAM (`sram`): reads a contiguous address range and emits it as an AXI4-Stream master toward the DMA MM2S/S2MM path.
- Drives the RAM's ce/write/addr inputs and takes its registered read data, which has 1-cycle latency.
- Absorbs stream backpressure with a 2-entry output buffer. Sustains 1 beat/cycle while tready is held high.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM word width and tdata width.
- LEN_WIDTH, ADDR_WIDTH+1, width of transfer length; allows a full-depth transfer of 2^ADDR_WIDTH words.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_start  in  1  1-cycle request to begin a transfer; ignored while o_busy=1.
- i_base_addr  in  ADDR_WIDTH  first RAM address, sampled with i_start.
- i_len  in  LEN_WIDTH  number of words to read, sampled with i_start.
- o_busy  out  1  high from the cycle after an accepted start until the done pulse.
- o_done  out  1  1-cycle pulse when the transfer completes.
- o_bram_ce  out  1  RAM chip enable (read issue).
- o_bram_write  out  1  RAM write enable; constant 0.
- o_bram_addr  out  ADDR_WIDTH  RAM address.
- i_bram_data  in  DATA_WIDTH  RAM registered read data.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  marks the final beat.

Behaviour:
- Reset (rstn=0, takes effect immediately, independent of clock):
  - state=IDLE.
  - o_busy, o_done, o_bram_ce, m_axis_tvalid, m_axis_tlast = 0.
  - o_bram_addr, m_axis_tdata = 0.
  - Issue counter, beat counter, pending flag and buffer count = 0.
  - Reset mid-transfer abandons the transfer silently: no done pulse, and buffered beats are discarded.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - i_start=1 at an edge captures base and len.
  - len=0: go directly to o_done=1 for one cycle and stay IDLE. o_busy stays 0 and no beat is produced.
  - Otherwise go to RUN.
- RUN, read issue:
  - Combinationally, o_bram_ce = (issued < len) && (count + pending − pop < 2), where pop = tvalid && tready.
  - o_bram_addr = base + issued, truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH (base=0xFE, len=4 reads FE,FF,00,01).
  - Each issue sets pending for the next cycle. In that cycle, i_bram_data is pushed into the buffer.
  - Once issued == len and pending = 0, go to FLUSH.
- FLUSH:
  - Wait until the buffer is empty with the last beat accepted.
  - On the last accepted beat: o_done=1 for one cycle, o_busy drops in the same cycle, return to IDLE.
- Buffer:
  - 2-entry FIFO, head drives tdata/tvalid.
  - tvalid is high whenever the buffer is non-empty.
  - tdata/tlast are held stable while tvalid && !tready (AXI rule).
  - Simultaneous push and pop is allowed and leaves the count unchanged.
  - Overflow is impossible by the credit rule; a bench assertion checks it.
- tlast = 1 exactly on beat index len−1, carried per buffer entry.
- Latency: start sampled at edge E0; ce high in cycle E0..E1; data pushed at E2; tvalid first high after E2 (2 cycles).
- Throughput: with tready held high, one beat per cycle after the initial latency, with no bubbles.
- Backpressure:
  - With tready=0, at most 2 reads are outstanding or buffered, then ce=0.
  - Issue resumes in the same cycle that tready returns to 1.
- i_start while busy: ignored, with no effect on the current transfer.
- i_base_addr/i_len changing after capture: no effect.

Decomposition:
- Shared include header holds:
  - state encodings IDLE/RUN/FLUSH;
  - the FIFO depth constant (2).
- One sub-module, `axis_fifo2`: a 2-entry valid/ready buffer with a {tlast, tdata} payload, push/pop, and count output.
- The top level holds the FSM, counters and credit logic.

Test Plan:
- RAM preloaded 0x10..0x17, start base=0, len=8, tready=1 → beats 0x10..0x17 on 8 consecutive cycles starting 2 cycles after start; tlast only on 0x17; o_done one cycle after the last handshake edge.
- Same transfer with tready toggled 1,0,0,1,… → identical data order; tdata stable while stalled; ce never high while buffer count + pending = 2.
- base=0xFE, len=4, RAM[FE,FF,00,01]=A,B,C,D → addresses FE,FF,00,01; beats A,B,C,D; tlast on D.
- len=0 → o_done pulses the cycle after start; o_busy, tvalid and ce stay 0.
- len=1 → single beat with tlast=1; done follows it. A second i_start issued mid-transfer of a len=6 run is ignored: exactly 6 beats.
- rstn asserted asynchronously mid-transfer with tvalid=1 → tvalid, busy and ce drop immediately with no done. A new start after release streams correctly from its own base.

Source files
------------

// File: rtl/bram_axis_reader_pkg.sv
// Shared definitions for the BRAM-to-AXI4-Stream reader: FSM states and buffer depth.
package bram_axis_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_axis_reader_if.sv
// Control, RAM-side and stream-side signals of the reader, grouped with the
// reader (master) and its environment (slave) views.
interface bram_axis_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);

  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_base_addr;
  logic [LEN_WIDTH-1:0]  i_len;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_bram_ce;
  logic                  o_bram_write;
  logic [ADDR_WIDTH-1:0] o_bram_addr;
  logic [DATA_WIDTH-1:0] i_bram_data;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    input  i_start, i_base_addr, i_len, i_bram_data, m_axis_tready,
    output o_busy, o_done, o_bram_ce, o_bram_write, o_bram_addr,
           m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output i_start, i_base_addr, i_len, i_bram_data, m_axis_tready,
    input  o_busy, o_done, o_bram_ce, o_bram_write, o_bram_addr,
           m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/bram_axis_reader_axis_fifo2.sv
// Two-entry valid/ready output buffer; the head entry drives the stream and
// stays put until popped, so the payload is stable under backpressure.
module axis_fifo2
  import bram_axis_reader_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign do_pop     = pop && (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bram_axis_reader.sv
// Reads a contiguous RAM range (1-cycle read latency) and streams it out as
// AXI4-Stream, issuing reads only while the 2-entry buffer has room.
module bram_axis_reader
  import bram_axis_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                i_clk,
  input  logic                rstn,
  bram_axis_reader_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;

  logic                  ce;
  logic                  pop;
  logic                  push_last;
  logic                  head_valid;
  logic [DATA_WIDTH:0]   head_data;
  logic [CNT_W-1:0]      fifo_count;
  logic [OCC_W-1:0]      occupancy;

  // A read may issue only if, after this cycle's pop, buffered plus in-flight
  // words still leave a free slot for the word it returns.
  assign pop       = head_valid && bus.m_axis_tready;
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(pending_q) - OCC_W'(pop);
  assign ce        = (state_q == RUN) && (issued_q < len_q) &&
                     (occupancy < OCC_W'(FIFO_DEPTH));
  assign push_last = (beat_q == (len_q - LEN_WIDTH'(1)));

  assign bus.o_bram_ce     = ce;
  assign bus.o_bram_write  = 1'b0;
  assign bus.o_bram_addr   = base_q + issued_q[ADDR_WIDTH-1:0];
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_done        = done_q;
  assign bus.m_axis_tvalid = head_valid;
  assign bus.m_axis_tdata  = head_data[DATA_WIDTH-1:0];
  assign bus.m_axis_tlast  = head_data[DATA_WIDTH];

  axis_fifo2 #(
    .WIDTH (DATA_WIDTH + 1),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (i_clk),
    .rst_n      (rstn),
    .push       (pending_q),
    .push_data  ({push_last, bus.i_bram_data}),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    issued_d  = issued_q;
    beat_d    = beat_q;
    pending_d = ce;
    done_d    = 1'b0;
    if (ce) begin
      issued_d = issued_q + LEN_WIDTH'(1);
    end
    if (pending_q) begin
      beat_d = beat_q + LEN_WIDTH'(1);
    end
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          base_d   = bus.i_base_addr;
          len_d    = bus.i_len;
          issued_d = '0;
          beat_d   = '0;
          if (bus.i_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      // The final beat can be accepted before FLUSH is reached, so both
      // states finish on the handshake of the tagged last beat.
      RUN: begin
        if (pop && head_data[DATA_WIDTH]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if ((issued_q == len_q) && !pending_q) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (pop && head_data[DATA_WIDTH]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      beat_q    <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      beat_q    <= beat_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_bram_axis_reader.sv
// Directed, table-driven bench for bram_axis_reader with a behavioural RAM,
// a stream monitor and hand-written len=0 / async-reset sequences.
module tb_bram_axis_reader;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 9;

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    int            ready_mode;
    bit            second_start;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bram_axis_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  bram_axis_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .i_clk (clk),
    .rstn  (rstn),
    .bus   (bus)
  );

  logic [DW-1:0] ram [256];
  vec_t          vecs [5];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;

  logic [DW-1:0] beat_data_q [$];
  logic          beat_last_q [$];
  int            beat_edge_q [$];
  logic [AW-1:0] addr_q [$];
  int            done_cnt  = 0;
  int            done_edge = 0;
  bit            stall_pend = 1'b0;
  logic [DW:0]   stall_val;

  always @(posedge clk) begin
    if (bus.o_bram_ce && !bus.o_bram_write) begin
      bus.i_bram_data <= ram[bus.o_bram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream/RAM monitor: a handshake seen at this negedge completes at the
  // next posedge, numbered cyc+1.
  always @(negedge clk) begin
    int  occ;
    bit  pop;
    if (rstn) begin
      pop = bus.m_axis_tvalid && bus.m_axis_tready;
      if (stall_pend) begin
        check_output("stall_hold", 32'({bus.m_axis_tlast, bus.m_axis_tdata}), 32'(stall_val));
      end
      stall_pend = bus.m_axis_tvalid && !bus.m_axis_tready;
      stall_val  = {bus.m_axis_tlast, bus.m_axis_tdata};
      if (pop) begin
        beat_data_q.push_back(bus.m_axis_tdata);
        beat_last_q.push_back(bus.m_axis_tlast);
        beat_edge_q.push_back(cyc + 1);
      end
      if (bus.o_bram_ce) begin
        addr_q.push_back(bus.o_bram_addr);
        occ = int'(dut.u_fifo.count_q) + int'(dut.pending_q) - int'(pop);
        check_output("ce_credit", 32'(occ < 2), 32'd1);
      end
      if (dut.pending_q) begin
        check_output("fifo_overflow", 32'((dut.u_fifo.count_q == 2'd2) && !pop), 32'd0);
      end
      if (bus.o_done) begin
        done_cnt++;
        done_edge = cyc;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic apply_stimulus(input vec_t v);
    int            start_edge;
    int            n;
    logic [AW-1:0] a;
    beat_data_q.delete();
    beat_last_q.delete();
    beat_edge_q.delete();
    addr_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    bus.i_start       = 1'b1;
    bus.i_base_addr   = v.base;
    bus.i_len         = v.len;
    bus.m_axis_tready = 1'b1;
    start_edge        = cyc + 1;
    for (int t = 0; t < 300 && done_cnt == 0; t++) begin
      @(posedge clk); #1;
      bus.m_axis_tready = (v.ready_mode == 0) ? 1'b1 : ((t % 3) == 0);
      bus.i_start       = v.second_start && (t == 2);
      bus.i_base_addr   = (t == 2) ? 8'h40 : 8'h33;
      bus.i_len         = (t == 2) ? 9'd3 : 9'd2;
    end
    bus.i_start       = 1'b0;
    bus.m_axis_tready = 1'b1;
    if (done_cnt == 0) check_output("done_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    n = beat_data_q.size();
    check_output("beat_count", 32'(n), 32'(v.len));
    check_output("addr_count", 32'(addr_q.size()), 32'(v.len));
    for (int i = 0; i < int'(v.len) && i < n; i++) begin
      a = v.base + 8'(i);
      check_output("beat_data", 32'(beat_data_q[i]), 32'(ram[a]));
      check_output("beat_tlast", 32'(beat_last_q[i]), 32'(i == int'(v.len) - 1));
      if (i < addr_q.size()) check_output("bram_addr", 32'(addr_q[i]), 32'(a));
    end
    if (n > 0) begin
      check_output("first_beat", 32'(beat_data_q[0]), 32'(v.exp_first));
      check_output("last_beat", 32'(beat_data_q[n-1]), 32'(v.exp_last));
      check_output("done_edge", 32'(done_edge), 32'(beat_edge_q[n-1]));
      if (v.ready_mode == 0) begin
        check_output("first_edge", 32'(beat_edge_q[0]), 32'(start_edge + 3));
        check_output("last_edge", 32'(beat_edge_q[n-1]), 32'(start_edge + 2 + int'(v.len)));
      end
    end
    check_output("done_count", 32'(done_cnt), 32'd1);
    check_output("idle_busy", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    bus.i_start       = 1'b0;
    bus.i_base_addr   = '0;
    bus.i_len         = '0;
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hC3;
    for (int i = 0; i < 8; i++) ram[i] = 8'h10 + 8'(i);
    ram[8'hFE] = 8'hA1;
    ram[8'hFF] = 8'hB2;

    vecs[0] = '{8'h00, 9'd8, 0, 1'b0, 8'h10, 8'h17};
    vecs[1] = '{8'h00, 9'd8, 1, 1'b0, 8'h10, 8'h17};
    vecs[2] = '{8'hFE, 9'd4, 0, 1'b0, 8'hA1, 8'hD4};
    vecs[3] = '{8'h05, 9'd1, 0, 1'b0, 8'h15, 8'h15};
    vecs[4] = '{8'h02, 9'd6, 1, 1'b1, 8'h12, 8'h17};

    repeat (2) @(negedge clk);
    check_output("rst_busy",   32'(bus.o_busy), 32'd0);
    check_output("rst_done",   32'(bus.o_done), 32'd0);
    check_output("rst_ce",     32'(bus.o_bram_ce), 32'd0);
    check_output("rst_write",  32'(bus.o_bram_write), 32'd0);
    check_output("rst_addr",   32'(bus.o_bram_addr), 32'd0);
    check_output("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check_output("rst_tlast",  32'(bus.m_axis_tlast), 32'd0);
    check_output("rst_tdata",  32'(bus.m_axis_tdata), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        ram[8'h00] = 8'hC3;
        ram[8'h01] = 8'hD4;
      end
      apply_stimulus(vecs[i]);
    end

    // Zero-length request: done pulses once, nothing else moves.
    done_cnt = 0;
    @(posedge clk); #1;
    bus.i_start     = 1'b1;
    bus.i_base_addr = 8'h20;
    bus.i_len       = 9'd0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    check_output("len0_done",   32'(bus.o_done), 32'd1);
    check_output("len0_busy",   32'(bus.o_busy), 32'd0);
    check_output("len0_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check_output("len0_ce",     32'(bus.o_bram_ce), 32'd0);
    @(negedge clk);
    check_output("len0_done_end", 32'(bus.o_done), 32'd0);
    check_output("len0_busy_end", 32'(bus.o_busy), 32'd0);
    check_output("len0_done_cnt", 32'(done_cnt), 32'd1);

    // Async reset while a beat is waiting under backpressure.
    done_cnt = 0;
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b0;
    bus.i_start       = 1'b1;
    bus.i_base_addr   = 8'h00;
    bus.i_len         = 9'd8;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int t = 0; t < 20 && !bus.m_axis_tvalid; t++) @(negedge clk);
    @(negedge clk);
    check_output("pre_rst_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_output("arst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check_output("arst_busy",   32'(bus.o_busy), 32'd0);
    check_output("arst_ce",     32'(bus.o_bram_ce), 32'd0);
    check_output("arst_done",   32'(bus.o_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn              = 1'b1;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("arst_no_done", 32'(done_cnt), 32'd0);
    check_output("arst_idle_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    apply_stimulus(vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
